rob_squash_sequencer: RTL and testbench
=======================================

Name: rob_squash_sequencer

Overview:
- Recovery controller for the 64-entry, 4-wide reorder buffer.
- The ROB has a single flush port (flushInst/flushIndex, one entry per cycle). This block takes squash requests from two requesters, arbitrates between them, and walks the doomed index range one entry per cycle.
- Requesters: branch-mispredict unit (kill from a given index to the tail) and commit/exception unit (kill everything from head to tail).
- While recovering it stalls dispatch; on completion it reports the rolled-back tail pointer.

Parameters:
- IDX_W, 6, width of a ROB index.
- DEPTH, 64, ROB entries (2**IDX_W); index arithmetic is modulo DEPTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- br_squash_req  in  1  branch mispredict; kill entries from br_squash_index up to rob_tail (exclusive)
- br_squash_index  in  IDX_W  first entry to kill (entry after the branch)
- exc_squash_req  in  1  exception at head; kill entries from rob_head up to rob_tail (exclusive)
- rob_head  in  IDX_W  current ROB head pointer
- rob_tail  in  IDX_W  current ROB tail pointer
- flush_inst  out  1  drives ROB flushInst
- flush_index  out  IDX_W  drives ROB flushIndex
- dispatch_stall  out  1  blocks ROB insertion (forces inserted to 0 upstream)
- busy  out  1  sequencer not idle
- done  out  1  one-cycle pulse; recovery finished
- new_tail_valid  out  1  equals done; ROB tail to be overwritten
- new_tail  out  IDX_W  rolled-back tail (= start index of the squash)
- squash_count  out  IDX_W+1  entries killed by the last completed recovery

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - flush_inst=0, flush_index=0, busy=0, done=0, new_tail_valid=0, new_tail=0, squash_count=0.
  - Reset mid-walk aborts immediately; no done is issued.
- States: IDLE, WALK, DONE.
- Arbitration in IDLE:
  - exc_squash_req has priority: start=rob_head, kind=EXC.
  - Otherwise br_squash_req: start=br_squash_index, kind=BR.
  - Latch start, end=rob_tail and remaining=(end-start) mod DEPTH, all sampled on the same edge.
- remaining==0 (nothing younger): IDLE->DONE directly, no flush issued, squash_count=0.
- remaining>0: IDLE->WALK.
- WALK:
  - flush_inst=1 every cycle.
  - flush_index starts at start and increments by 1 per cycle, wrapping 63->0.
  - remaining decrements each cycle; after the cycle in which remaining==1 the state goes to DONE.
  - Exactly remaining flushes are issued, at one per cycle, never skipped or repeated.
- DONE (one cycle):
  - done=1, new_tail_valid=1, new_tail=start.
  - squash_count=number of entries flushed; it holds until the next DONE.
  - Then DONE->IDLE. A new request present in DONE is accepted on the following IDLE cycle.
- Latency: request at edge N gives the first flush_inst at cycle N+1. Done occurs at cycle N+1+remaining (N+1 when remaining=0).
- Requests arriving during WALK:
  - exc_squash_req always restarts the walk: start=rob_head, end unchanged, remaining recomputed against the latched end. The restart is legal because exc covers every older entry.
  - br_squash_req restarts only if it is older than the current start, i.e. (br_squash_index-rob_head) < (start-rob_head) mod DEPTH. Otherwise it is ignored, because the range is already covered.
  - On a restart, flush_index jumps to the new start next cycle. Entries already flushed are not re-flushed unless they fall in the new range; re-flushing is harmless.
- Simultaneous exc and br requests in any state: exc wins and br is dropped.
- busy = (state != IDLE).
- dispatch_stall = busy | br_squash_req | exc_squash_req. It is combinational, so insertion is blocked in the request cycle itself.
- The latched end is never updated from rob_tail after acceptance; the ROB cannot insert while stalled.
- All pointer arithmetic is IDX_W bits modulo DEPTH. squash_count is IDX_W+1 bits so the value 63 fits with margin.

Test Plan:
- Branch, no wrap: head=0, tail=10, br_squash_index=4 → flush_index 4,5,…,9 on 6 consecutive cycles; done at cycle 7; new_tail=4; squash_count=6.
- Wrap-around: head=60, tail=2, br_squash_index=62 → flushes 62,63,0,1; new_tail=62; squash_count=4.
- Priority: br (index 8) and exc (head=3, tail=12) on the same edge → flushes 3..11 (9 cycles); new_tail=3; br ignored.
- Restart: br at index 20 with tail=30; at the 3rd flush (index 22) br index 15 arrives → next flush 15, continuing 16..29; squash_count=15. A later br at index 25 during the walk is ignored.
- Empty range: br_squash_index==rob_tail=7 → no flush_inst; done one cycle after the request; squash_count=0; dispatch_stall high for exactly 2 cycles.
- Reset mid-walk: reset=0 during the 2nd flush → next cycle flush_inst=0, busy=0, no done. A subsequent request works normally.

Source files
------------

// File: rtl/rob_squash_sequencer.sv
// ROB recovery sequencer: arbitrates branch/exception squash requests and
// walks the doomed index range through the single ROB flush port.
module rob_squash_sequencer #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_squash_req,
  input  logic [IDX_W-1:0] br_squash_index,
  input  logic             exc_squash_req,
  input  logic [IDX_W-1:0] rob_head,
  input  logic [IDX_W-1:0] rob_tail,
  output logic             flush_inst,
  output logic [IDX_W-1:0] flush_index,
  output logic             dispatch_stall,
  output logic             busy,
  output logic             done,
  output logic             new_tail_valid,
  output logic [IDX_W-1:0] new_tail,
  output logic [IDX_W:0]   squash_count
);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [IDX_W-1:0] r_start, w_start_nx;
  logic [IDX_W-1:0] r_end, w_end_nx;
  logic [IDX_W-1:0] r_rem, w_rem_nx;
  logic [IDX_W-1:0] r_idx, w_idx_nx;
  logic [IDX_W-1:0] r_new_tail;
  logic [IDX_W:0]   r_squash_count;
  logic [IDX_W-1:0] w_new_start;
  logic             w_load;
  logic             w_br_older;
  logic             w_finish;

  function automatic logic [IDX_W-1:0] mod_sub(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b);
    return IDX_W'((DEPTH + a - b) % DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] mod_inc(input logic [IDX_W-1:0] a);
    return IDX_W'((a + 1) % DEPTH);
  endfunction

  always_comb begin
    w_state_nx  = r_state;
    w_start_nx  = r_start;
    w_end_nx    = r_end;
    w_rem_nx    = r_rem;
    w_idx_nx    = r_idx;
    w_load      = 1'b0;
    w_new_start = exc_squash_req ? rob_head : br_squash_index;
    // Age relative to head: smaller distance from head means older entry.
    w_br_older  = mod_sub(br_squash_index, rob_head) < mod_sub(r_start, rob_head);
    flush_inst  = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (exc_squash_req || br_squash_req) begin
          w_end_nx = rob_tail;
          w_load   = 1'b1;
        end
      end
      S_WALK: begin
        flush_inst = 1'b1;
        if (exc_squash_req || (br_squash_req && w_br_older)) begin
          w_load = 1'b1;
        end else begin
          w_idx_nx = mod_inc(r_idx);
          w_rem_nx = r_rem - 1'b1;
          if (r_rem == IDX_W'(1)) w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase

    // New walk or restart: range is always measured against the latched end.
    if (w_load) begin
      w_start_nx = w_new_start;
      w_idx_nx   = w_new_start;
      w_rem_nx   = mod_sub(w_end_nx, w_new_start);
      w_state_nx = (w_rem_nx == '0) ? S_DONE : S_WALK;
    end

    w_finish       = (w_state_nx == S_DONE) && (r_state != S_DONE);
    flush_index    = r_idx;
    new_tail_valid = done;
    new_tail       = r_new_tail;
    squash_count   = r_squash_count;
    dispatch_stall = busy | br_squash_req | exc_squash_req;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_start        <= '0;
      r_end          <= '0;
      r_rem          <= '0;
      r_idx          <= '0;
      r_new_tail     <= '0;
      r_squash_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_start <= w_start_nx;
      r_end   <= w_end_nx;
      r_rem   <= w_rem_nx;
      r_idx   <= w_idx_nx;
      if (w_finish) begin
        r_new_tail     <= w_start_nx;
        r_squash_count <= {1'b0, mod_sub(w_end_nx, w_start_nx)};
      end
    end
  end

endmodule

// File: tb/tb_rob_squash_sequencer.sv
// Bench for rob_squash_sequencer: directed table, corner sequences, and
// random traffic checked every cycle against a flush-list reference model.
module tb_rob_squash_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       br_squash_req;
  logic [5:0] br_squash_index;
  logic       exc_squash_req;
  logic [5:0] rob_head;
  logic [5:0] rob_tail;
  logic       flush_inst;
  logic [5:0] flush_index;
  logic       dispatch_stall;
  logic       busy;
  logic       done;
  logic       new_tail_valid;
  logic [5:0] new_tail;
  logic [6:0] squash_count;

  rob_squash_sequencer #(.IDX_W(6), .DEPTH(64)) dut (
    .clk(clk), .reset(reset),
    .br_squash_req(br_squash_req), .br_squash_index(br_squash_index),
    .exc_squash_req(exc_squash_req), .rob_head(rob_head), .rob_tail(rob_tail),
    .flush_inst(flush_inst), .flush_index(flush_index),
    .dispatch_stall(dispatch_stall), .busy(busy), .done(done),
    .new_tail_valid(new_tail_valid), .new_tail(new_tail),
    .squash_count(squash_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the pending recovery is an explicit list of indices.
  int q[$];
  bit m_busy, m_done, m_after_reset;
  int m_start, m_end, m_nt, m_cnt;

  // Last observed DUT outputs.
  int g_flush, g_idx, g_done, g_stall, g_nt, g_cnt, g_busy;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_build(input int s);
    m_start = s;
    q.delete();
    for (int k = s; k != m_end; k = (k + 1) % 64) q.push_back(k);
  endfunction

  function automatic void model_edge();
    if (!reset) begin
      q.delete();
      m_busy = 0; m_done = 0; m_nt = 0; m_cnt = 0; m_after_reset = 1;
      return;
    end
    m_after_reset = 0;
    if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (exc_squash_req || br_squash_req) begin
        m_end  = rob_tail;
        m_busy = 1;
        m_build(exc_squash_req ? int'(rob_head) : int'(br_squash_index));
        if (q.size() == 0) begin m_done = 1; m_nt = m_start; m_cnt = 0; end
      end
    end else begin
      if (exc_squash_req)
        m_build(rob_head);
      else if (br_squash_req &&
               ((br_squash_index - rob_head) & 63) < ((m_start - rob_head) & 63))
        m_build(br_squash_index);
      else
        void'(q.pop_front());
      if (q.size() == 0) begin
        m_done = 1; m_nt = m_start; m_cnt = (m_end - m_start) & 63;
      end
    end
  endfunction

  // Called just after a negedge with inputs driven; checks, then advances one clock.
  task automatic cycle();
    bit walking;
    #1;
    g_flush = flush_inst; g_idx = flush_index; g_done = done; g_busy = busy;
    g_stall = dispatch_stall; g_nt = new_tail; g_cnt = squash_count;
    walking = m_busy && !m_done;
    chk("flush_inst", flush_inst, walking);
    if (walking) chk("flush_index", flush_index, q[0]);
    else if (m_after_reset) chk("flush_index_rst", flush_index, 0);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("new_tail_valid", new_tail_valid, m_done);
    chk("new_tail", new_tail, m_nt);
    chk("squash_count", squash_count, m_cnt);
    chk("dispatch_stall", dispatch_stall, m_busy | br_squash_req | exc_squash_req);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_req(input logic br, input logic [5:0] bidx, input logic exc,
                         input logic [5:0] head, input logic [5:0] tail,
                         input int exp_nt, input int exp_cnt);
    int done_at = -1, flushes = 0, stalls = 0;
    br_squash_req = br; br_squash_index = bidx; exc_squash_req = exc;
    rob_head = head; rob_tail = tail;
    for (int c = 0; c < 100 && done_at < 0; c++) begin
      cycle();
      br_squash_req = 0; exc_squash_req = 0;
      if (g_stall != 0) stalls++;
      if (g_flush != 0) begin
        chk("walk_seq", g_idx, (exp_nt + flushes) % 64);
        flushes++;
      end
      if (g_done != 0) done_at = c;
    end
    chk("done_seen", int'(done_at >= 0), 1);
    chk("done_latency", done_at, 1 + exp_cnt);
    chk("flush_total", flushes, exp_cnt);
    chk("vec_new_tail", g_nt, exp_nt);
    chk("vec_count", g_cnt, exp_cnt);
    chk("stall_cycles", stalls, exp_cnt + 2);
    cycle();
  endtask

  typedef struct {
    logic br; logic [5:0] bidx; logic exc; logic [5:0] head; logic [5:0] tail;
    int exp_nt; int exp_cnt;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int done_cyc, flushes;
    vecs[0] = '{1'b1, 6'd4,  1'b0, 6'd0,  6'd10, 4,  6};
    vecs[1] = '{1'b1, 6'd62, 1'b0, 6'd60, 6'd2,  62, 4};
    vecs[2] = '{1'b1, 6'd8,  1'b1, 6'd3,  6'd12, 3,  9};
    vecs[3] = '{1'b1, 6'd7,  1'b0, 6'd0,  6'd7,  7,  0};
    vecs[4] = '{1'b0, 6'd0,  1'b1, 6'd50, 6'd50, 50, 0};
    vecs[5] = '{1'b0, 6'd0,  1'b1, 6'd40, 6'd39, 40, 63};

    reset = 0; br_squash_req = 0; exc_squash_req = 0;
    br_squash_index = 0; rob_head = 0; rob_tail = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_edge();
    cycle();
    reset = 1;
    cycle();

    foreach (vecs[i])
      run_req(vecs[i].br, vecs[i].bidx, vecs[i].exc, vecs[i].head, vecs[i].tail,
              vecs[i].exp_nt, vecs[i].exp_cnt);

    // Older branch restarts the walk; a younger one later is ignored.
    rob_head = 10; rob_tail = 30; br_squash_req = 1; br_squash_index = 20;
    cycle();                               // c0
    br_squash_req = 0;
    cycle(); chk("rs_first", g_idx, 20);   // c1
    cycle();                               // c2
    br_squash_req = 1; br_squash_index = 15;
    cycle(); chk("rs_third", g_idx, 22);   // c3
    br_squash_req = 0;
    cycle(); chk("rs_jump", g_idx, 15);    // c4
    cycle();                               // c5
    br_squash_req = 1; br_squash_index = 25;
    cycle();                               // c6
    br_squash_req = 0;
    done_cyc = -1; flushes = 0;
    for (int c = 7; c < 60 && done_cyc < 0; c++) begin
      cycle();
      if (g_flush != 0) flushes++;
      if (g_done != 0) done_cyc = c;
    end
    chk("rs_done_cycle", done_cyc, 19);
    chk("rs_tail_flushes", flushes, 12);
    chk("rs_new_tail", g_nt, 15);
    chk("rs_count", g_cnt, 15);
    cycle();

    // Reset during the second flush aborts the walk without done.
    rob_head = 0; rob_tail = 10; br_squash_req = 1; br_squash_index = 4;
    cycle();
    br_squash_req = 0;
    cycle();
    reset = 0;
    cycle(); chk("rst_second_flush", g_idx, 5);
    reset = 1;
    cycle();
    chk("rst_flush_off", g_flush, 0);
    chk("rst_busy_off", g_busy, 0);
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("rst_no_done", g_done, 0);
    end
    run_req(vecs[0].br, vecs[0].bidx, vecs[0].exc, vecs[0].head, vecs[0].tail,
            vecs[0].exp_nt, vecs[0].exp_cnt);

    // Random traffic, including restarts, collisions and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rob_head        = 6'($urandom);
      rob_tail        = 6'($urandom);
      br_squash_index = 6'($urandom);
      br_squash_req   = ($urandom % 6) == 0;
      exc_squash_req  = ($urandom % 12) == 0;
      reset           = ($urandom % 300) != 0;
      cycle();
    end
    reset = 1; br_squash_req = 0; exc_squash_req = 0;
    repeat (70) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
